// File: rtl/timer_pkg.sv
// Shared state encoding and default sizing for the countdown timer slice.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } t_timer_state;

    localparam int P_DIV_DEF   = 50000;
    localparam int P_CNT_W_DEF = 16;

endpackage

// File: rtl/tick_div.sv
// Free-running divide-by-P_DIV prescaler with hold and synchronous clear.
module tick_div
    import timer_pkg::*;
#(
    parameter int P_DIV = P_DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic sclr_i,
    output logic tick_o
);

    localparam int             W    = $clog2(P_DIV);
    localparam logic [W-1:0]   LAST = W'(P_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sclr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The tick marks the last count of a period, so the consumer acts on the wrapping edge.
    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer: command FSM plus remaining-tick register, sequencing a tick_div prescaler.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int P_DIV   = P_DIV_DEF,
    parameter int P_CNT_W = P_CNT_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [P_CNT_W-1:0] load_val_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               clear_i,
    output logic [P_CNT_W-1:0] remain_o,
    output logic               running_o,
    output logic               paused_o,
    output logic               done_o,
    output logic               tick_o
);

    t_timer_state       state_q, state_d;
    logic [P_CNT_W-1:0] remain_q, remain_d;
    logic               done_q, done_d;
    logic               divEn;
    logic               divSclr;
    logic               divTick;

    assign divEn = (state_q == RUN);

    tick_div #(
        .P_DIV (P_DIV)
    ) uTickDiv (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (divEn),
        .sclr_i (divSclr),
        .tick_o (divTick)
    );

    // Commands are resolved clear > load > stop > start; a command not valid in the current state falls through.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        divSclr  = 1'b0;
        if (clear_i) begin
            state_d  = IDLE;
            remain_d = '0;
            divSclr  = 1'b1;
        end else if (load_i && (state_q != RUN)) begin
            state_d  = IDLE;
            remain_d = load_val_i;
            divSclr  = 1'b1;
        end else if (state_q == RUN) begin
            if (divTick) begin
                if (remain_q <= P_CNT_W'(1)) begin
                    remain_d = '0;
                    state_d  = EXPIRED;
                    done_d   = 1'b1;
                    divSclr  = 1'b1;
                end else begin
                    remain_d = remain_q - 1'b1;
                    if (stop_i) begin
                        state_d = PAUSE;
                    end
                end
            end else if (stop_i) begin
                state_d = PAUSE;
            end
        end else if (start_i && (remain_q != '0)) begin
            if (state_q == IDLE) begin
                state_d = RUN;
                divSclr = 1'b1;
            end else if (state_q == PAUSE) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            done_q   <= done_d;
        end
    end

    assign remain_o  = remain_q;
    assign running_o = (state_q == RUN);
    assign paused_o  = (state_q == PAUSE);
    assign done_o    = done_q;
    assign tick_o    = divTick;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: cycle model of the timer rules plus directed scenarios with literal expectations.
module tb_timer_ctrl;

    localparam int TB_DIV = 4;
    localparam int TB_W   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load = 1'b0;
    logic [TB_W-1:0] loadVal = '0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            clear = 1'b0;
    logic [TB_W-1:0] remain;
    logic            running;
    logic            paused;
    logic            done;
    logic            tick;

    logic            load2 = 1'b0;
    logic [15:0]     loadVal2 = '0;
    logic            start2 = 1'b0;
    logic            stop2 = 1'b0;
    logic            clear2 = 1'b0;
    logic [15:0]     remain2;
    logic            running2;
    logic            paused2;
    logic            done2;
    logic            tick2;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    timer_ctrl #(
        .P_DIV   (TB_DIV),
        .P_CNT_W (TB_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (load),
        .load_val_i (loadVal),
        .start_i    (start),
        .stop_i     (stop),
        .clear_i    (clear),
        .remain_o   (remain),
        .running_o  (running),
        .paused_o   (paused),
        .done_o     (done),
        .tick_o     (tick)
    );

    timer_ctrl dutDefault (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (load2),
        .load_val_i (loadVal2),
        .start_i    (start2),
        .stop_i     (stop2),
        .clear_i    (clear2),
        .remain_o   (remain2),
        .running_o  (running2),
        .paused_o   (paused2),
        .done_o     (done2),
        .tick_o     (tick2)
    );

    // Reference model: timer mode, ticks left, cycles elapsed in the current tick period.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mode_t;
    mode_t mMode    = M_IDLE;
    int    mRem     = 0;
    int    mElapsed = 0;
    bit    mDone    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mMode    <= M_IDLE;
            mRem     <= 0;
            mElapsed <= 0;
            mDone    <= 1'b0;
        end else begin
            mDone <= 1'b0;
            if (clear) begin
                mMode    <= M_IDLE;
                mRem     <= 0;
                mElapsed <= 0;
            end else if (load && mMode != M_RUN) begin
                mMode    <= M_IDLE;
                mRem     <= int'(loadVal);
                mElapsed <= 0;
            end else if (mMode == M_RUN) begin
                if (mElapsed == TB_DIV - 1) begin
                    mElapsed <= 0;
                    mRem     <= mRem - 1;
                    if (mRem == 1) begin
                        mMode <= M_EXP;
                        mDone <= 1'b1;
                    end else if (stop) begin
                        mMode <= M_PAUSE;
                    end
                end else begin
                    mElapsed <= mElapsed + 1;
                    if (stop) mMode <= M_PAUSE;
                end
            end else if (start && mRem != 0) begin
                if (mMode == M_IDLE) begin
                    mMode    <= M_RUN;
                    mElapsed <= 0;
                end else if (mMode == M_PAUSE) begin
                    mMode <= M_RUN;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model.remain",  int'(remain),  mRem);
        checkOutput("model.running", int'(running), int'(mMode == M_RUN));
        checkOutput("model.paused",  int'(paused),  int'(mMode == M_PAUSE));
        checkOutput("model.done",    int'(done),    int'(mDone));
        checkOutput("model.tick",    int'(tick),    int'(mMode == M_RUN && mElapsed == TB_DIV - 1));
    end

    // Called at a falling edge: commands are held for exactly one rising edge.
    task automatic applyStimulus(input logic ld, input logic [TB_W-1:0] val,
                                 input logic st, input logic sp, input logic cl);
        load    = ld;
        loadVal = val;
        start   = st;
        stop    = sp;
        clear   = cl;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    // Returns the rising edge (counted from the command edge) on which the next tick acts, or -1.
    task automatic nextTickEdge(input int budget, output int edgeIdx);
        edgeIdx = -1;
        for (int n = 0; n < budget; n++) begin
            if (tick) begin
                edgeIdx = n + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int tickEdges[$];
        int remainAt[16];
        int doneAt;
        int doneCount;
        int doneRunning;
        int edgeIdx;
        int holdOk;
        int firstTick2;
        int done2At;

        // Reset state while rst_n is held low.
        @(negedge clk);
        checkOutput("reset.remain",  int'(remain),  0);
        checkOutput("reset.running", int'(running), 0);
        checkOutput("reset.paused",  int'(paused),  0);
        checkOutput("reset.done",    int'(done),    0);
        checkOutput("reset.tick",    int'(tick),    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] start with nothing loaded, then load 0");
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t1.startEmpty.running", int'(running), 0);
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t1.loadZero.running", int'(running), 0);
        checkOutput("t1.loadZero.remain",  int'(remain),  0);

        $display("[TB] load 3 and run to expiry");
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("t2.loaded.remain", int'(remain), 3);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        doneAt = -1;
        doneCount = 0;
        doneRunning = -1;
        for (int n = 0; n < 16; n++) begin
            remainAt[n] = int'(remain);
            if (tick) tickEdges.push_back(n + 1);
            if (done) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt = n;
                    doneRunning = int'(running);
                end
            end
            @(negedge clk);
        end
        checkOutput("t2.tickCount", tickEdges.size(), 3);
        if (tickEdges.size() == 3) begin
            checkOutput("t2.tick1", tickEdges[0], 4);
            checkOutput("t2.tick2", tickEdges[1], 8);
            checkOutput("t2.tick3", tickEdges[2], 12);
        end
        checkOutput("t2.remainAfter1", remainAt[4], 2);
        checkOutput("t2.remainAfter2", remainAt[8], 1);
        checkOutput("t2.remainAfter3", remainAt[12], 0);
        checkOutput("t2.doneCycle", doneAt, 12);
        checkOutput("t2.doneWidth", doneCount, 1);
        checkOutput("t2.doneRunning", doneRunning, 0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t2.expiredStart.running", int'(running), 0);

        $display("[TB] pause mid-period and resume");
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3.stop.remain", int'(remain), 4);
        checkOutput("t3.stop.paused", int'(paused), 1);
        holdOk = 1;
        for (int n = 0; n < 20; n++) begin
            if (remain != 8'd4 || !paused) holdOk = 0;
            @(negedge clk);
        end
        checkOutput("t3.hold20", holdOk, 1);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        nextTickEdge(8, edgeIdx);
        checkOutput("t3.resumeTick", edgeIdx, 2);

        $display("[TB] stop on the tick edge");
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3b.stopTick.remain", int'(remain), 4);
        checkOutput("t3b.stopTick.paused", int'(paused), 1);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        nextTickEdge(8, edgeIdx);
        checkOutput("t3b.resumeTick", edgeIdx, 4);

        $display("[TB] commands while running");
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
        checkOutput("t4.loadInRun.remain",  int'(remain),  6);
        checkOutput("t4.loadInRun.running", int'(running), 1);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4.stopStart.paused", int'(paused), 1);
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("t4.loadInPause.remain", int'(remain), 2);
        checkOutput("t4.loadInPause.paused", int'(paused), 0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t4.restart.running", int'(running), 1);
        applyStimulus(1'b1, 8'd7, 1'b0, 1'b0, 1'b1);
        checkOutput("t4.clearLoad.remain",  int'(remain),  0);
        checkOutput("t4.clearLoad.running", int'(running), 0);

        $display("[TB] asynchronous reset mid-count");
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5.async.remain",  int'(remain),  0);
        checkOutput("t5.async.running", int'(running), 0);
        checkOutput("t5.async.paused",  int'(paused),  0);
        checkOutput("t5.async.done",    int'(done),    0);
        checkOutput("t5.async.tick",    int'(tick),    0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t5.afterRelease.running", int'(running), 0);
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5.restart.running", int'(running), 1);
        repeat (10) @(negedge clk);

        $display("[TB] default divider, load 1");
        load2 = 1'b1;
        loadVal2 = 16'd1;
        @(negedge clk);
        load2 = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        firstTick2 = -1;
        done2At = -1;
        for (int n = 0; n < 60000; n++) begin
            if (tick2 && firstTick2 < 0) firstTick2 = n + 1;
            if (done2) begin
                done2At = n;
                break;
            end
            @(negedge clk);
        end
        checkOutput("t6.firstTick", firstTick2, 50000);
        checkOutput("t6.doneCycle", done2At, 50000);
        checkOutput("t6.done.remain", int'(remain2), 0);
        checkOutput("t6.done.running", int'(running2), 0);
        checkOutput("t6.done.paused", int'(paused2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
